// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: load/store option encodings and FSM states shared by the MEM-stage access unit.
package mem_access_unit_pkg;
  typedef enum logic [2:0] {
    LD_W  = 3'b000,
    LD_BU = 3'b001,
    LD_B  = 3'b101,
    LD_HU = 3'b011,
    LD_H  = 3'b111
  } ld_opt_e;
  typedef enum logic [1:0] {
    SV_W = 2'b00,
    SV_B = 2'b01,
    SV_H = 2'b10
  } sv_opt_e;
  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_e;
endpackage

// File: rtl/mem_access_unit_lane_extract.sv
// mem_access_unit_lane_extract: selects the addressed byte/half of a read word and zero/sign-extends it.
module mem_access_unit_lane_extract (
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  load_option,
  output logic [31:0] result
);
  logic [7:0]  b;
  logic [15:0] h;
  assign b = rdata[{off, 3'b000} +: 8];
  assign h = off[1] ? rdata[31:16] : rdata[15:0];
  assign result = !load_option[0] ? rdata :
                  load_option[1]  ? {{16{load_option[2] & h[15]}}, h} :
                                    {{24{load_option[2] & b[7]}}, b};
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store engine driving a req/ack word bus with timeout abort.
// Optional MISALIGN_EXC_EN turns misaligned half/word accesses into address exceptions.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              acc_valid,
  input  logic              mem_write,
  input  logic              mem_read,
  input  logic [2:0]        load_option,
  input  logic [1:0]        save_option,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic [31:0]       ld_data,
  output logic              done,
  output logic              bus_err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [3:0]        bus_be,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  input  logic [31:0]       bus_rdata,
  input  logic              bus_ack
`ifdef MISALIGN_EXC_EN
  ,
  output logic              addr_exc,
  output logic [ADDR_W-1:0] bad_vaddr
`endif
);
  state_e      state;
  logic [15:0] cnt;
  logic        is_ld;
  logic        access;
  logic [1:0]  off;
  logic [3:0]  be_n;
  logic [31:0] wd_n;
  logic [31:0] ext;
  assign access = acc_valid & (mem_read | mem_write);
  assign stall  = access & (state != DONE);
  assign off    = addr[1:0];
  assign be_n = !mem_write           ? 4'b1111 :
                save_option == SV_B  ? 4'b0001 << off :
                save_option == SV_H  ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign wd_n = !mem_write           ? 32'h0 :
                save_option == SV_B  ? {4{wdata[7:0]}} :
                save_option == SV_H  ? {2{wdata[15:0]}} : wdata;
`ifdef MISALIGN_EXC_EN
  logic is_h, is_w, mis;
  assign is_h = mem_write ? save_option == SV_H : load_option[1:0] == 2'b11;
  assign is_w = mem_write ? (save_option != SV_B && save_option != SV_H) : !load_option[0];
  assign mis  = (is_h & addr[0]) | (is_w & (off != 2'b00));
`endif
  // Inputs are held stable through the ack cycle, so extraction uses them live.
  mem_access_unit_lane_extract u_lane_extract (
    .rdata(bus_rdata),
    .off(off),
    .load_option(load_option),
    .result(ext)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      is_ld     <= 1'b0;
      ld_data   <= '0;
      done      <= 1'b0;
      bus_err   <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_be    <= '0;
      bus_addr  <= '0;
      bus_wdata <= '0;
`ifdef MISALIGN_EXC_EN
      addr_exc  <= 1'b0;
      bad_vaddr <= '0;
`endif
    end else begin
      done    <= 1'b0;
      bus_err <= 1'b0;
`ifdef MISALIGN_EXC_EN
      addr_exc <= 1'b0;
`endif
      case (state)
        IDLE: if (access) begin
`ifdef MISALIGN_EXC_EN
          if (mis) begin
            state     <= DONE;
            done      <= 1'b1;
            addr_exc  <= 1'b1;
            bad_vaddr <= addr;
          end else begin
`else
          begin
`endif
            state     <= WAIT;
            cnt       <= '0;
            is_ld     <= !mem_write;
            bus_req   <= 1'b1;
            bus_we    <= mem_write;
            bus_be    <= be_n;
            bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
            bus_wdata <= wd_n;
          end
        end
        WAIT: if (bus_ack) begin
          state   <= DONE;
          done    <= 1'b1;
          bus_req <= 1'b0;
          if (is_ld) ld_data <= ext;
        end else if (cnt == 16'(TIMEOUT_CYCLES - 1)) begin
          state   <= DONE;
          done    <= 1'b1;
          bus_err <= 1'b1;
          bus_req <= 1'b0;
          ld_data <= '0;
        end else if (cnt != 16'hFFFF) begin
          cnt <= cnt + 16'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed bench with a done-driven scoreboard; a second instance covers the timeout path.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;
  typedef struct packed {
    logic [31:0] ld;
    logic        err;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        acc_valid = 1'b0, acc_valid_to = 1'b0;
  logic        mem_write = 1'b0, mem_read = 1'b0;
  logic [2:0]  load_option = 3'b000;
  logic [1:0]  save_option = 2'b00;
  logic [31:0] addr = '0, wdata = '0, bus_rdata = '0;
  logic        bus_ack = 1'b0;
  logic        stall, done, bus_err, bus_req, bus_we;
  logic [31:0] ld_data, bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        stall_to, done_to, bus_err_to, bus_req_to, bus_we_to;
  logic [31:0] ld_data_to, bus_addr_to, bus_wdata_to;
  logic [3:0]  bus_be_to;
`ifdef MISALIGN_EXC_EN
  logic        addr_exc, addr_exc_to;
  logic [31:0] bad_vaddr, bad_vaddr_to;
`endif
  logic [31:0] le_rdata = '0, le_result;
  logic [1:0]  le_off = '0;
  logic [2:0]  le_opt = '0;
  exp_t        sb[$];
  int          n_cmp = 0, n_bad = 0;
  logic [31:0] last_ld = '0;
  always #5 clk = ~clk;
  mem_access_unit dut (
    .clk(clk), .rst_n(rst_n), .acc_valid(acc_valid), .mem_write(mem_write), .mem_read(mem_read),
    .load_option(load_option), .save_option(save_option), .addr(addr), .wdata(wdata),
    .stall(stall), .ld_data(ld_data), .done(done), .bus_err(bus_err), .bus_req(bus_req),
    .bus_we(bus_we), .bus_be(bus_be), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack)
`ifdef MISALIGN_EXC_EN
    , .addr_exc(addr_exc), .bad_vaddr(bad_vaddr)
`endif
  );
  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut_to (
    .clk(clk), .rst_n(rst_n), .acc_valid(acc_valid_to), .mem_write(mem_write), .mem_read(mem_read),
    .load_option(load_option), .save_option(save_option), .addr(addr), .wdata(wdata),
    .stall(stall_to), .ld_data(ld_data_to), .done(done_to), .bus_err(bus_err_to), .bus_req(bus_req_to),
    .bus_we(bus_we_to), .bus_be(bus_be_to), .bus_addr(bus_addr_to), .bus_wdata(bus_wdata_to),
    .bus_rdata(bus_rdata), .bus_ack(1'b0)
`ifdef MISALIGN_EXC_EN
    , .addr_exc(addr_exc_to), .bad_vaddr(bad_vaddr_to)
`endif
  );
  mem_access_unit_lane_extract u_le (.rdata(le_rdata), .off(le_off), .load_option(le_opt), .result(le_result));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired", name);
  endtask
  // Monitor: every completion of either instance retires one scoreboard entry.
  always @(negedge clk) begin
    if (rst_n && (done || done_to)) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", {31'b0, done | done_to}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_ld_data", done ? ld_data : ld_data_to, e.ld);
        chk("sb_bus_err", {31'b0, done ? bus_err : bus_err_to}, {31'b0, e.err});
      end
    end
  end
  task automatic run(input logic mw, input logic mr, input logic [2:0] lo, input logic [1:0] so,
                     input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd, input int waits,
                     input logic [31:0] exp_ld, input logic [3:0] exp_be, input logic [31:0] exp_bwd);
    int st = 0, rq = 0;
    bit fin = 0;
    @(posedge clk); #1;
    acc_valid = 1; mem_write = mw; mem_read = mr; load_option = lo; save_option = so;
    addr = a; wdata = wd; bus_rdata = rd;
    sb.push_back('{exp_ld, 1'b0});
    for (int i = 0; i < 300 && !fin; i++) begin
      @(negedge clk);
      if (done) begin
        fin = 1;
        chk("done_cycle", i, waits + 2);
        chk("stall_cycles", st, waits + 2);
        chk("stall_in_done", {31'b0, stall}, 32'd0);
        acc_valid = 0;
        bus_ack = 0;
      end else begin
        if (stall) st++;
        if (bus_req) begin
          rq++;
          if (rq == 1) begin
            chk("bus_addr", bus_addr, {a[31:2], 2'b00});
            chk("bus_be", {28'b0, bus_be}, {28'b0, exp_be});
            chk("bus_we", {31'b0, bus_we}, {31'b0, mw});
            if (mw) chk("bus_wdata", bus_wdata, exp_bwd);
          end
          bus_ack = (rq == waits + 1);
        end
      end
    end
    if (!fin) begin
      fail("done_wait");
      acc_valid = 0;
      bus_ack = 0;
    end
    last_ld = exp_ld;
  endtask
  initial begin
    logic [31:0] v_rd [5] = '{32'h12F03456, 32'h12F03456, 32'h80017FFF, 32'h80017FFF, 32'hDEADBEEF};
    logic [1:0]  v_off[5] = '{2'd2, 2'd3, 2'd0, 2'd2, 2'd1};
    logic [2:0]  v_opt[5] = '{LD_B, LD_BU, LD_H, LD_HU, LD_W};
    logic [31:0] v_exp[5] = '{32'hFFFFFFF0, 32'h00000012, 32'h00007FFF, 32'h00008001, 32'hDEADBEEF};
    int rq;
    bit fin;
    for (int i = 0; i < 5; i++) begin
      le_rdata = v_rd[i]; le_off = v_off[i]; le_opt = v_opt[i];
      #1 chk("lane_extract", le_result, v_exp[i]);
    end
    repeat (3) @(negedge clk);
    chk("rst_bus_req", {31'b0, bus_req}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_ld_data", ld_data, 32'd0);
    rst_n = 1;
    run(1, 0, LD_W, SV_B, 32'h1003, 32'h000000A5, 32'h0, 0, last_ld, 4'b1000, 32'hA5A5A5A5);
    run(0, 1, LD_B, SV_W, 32'h2002, 32'h0, 32'h12F03456, 0, 32'hFFFFFFF0, 4'b1111, 32'h0);
    run(0, 1, LD_BU, SV_W, 32'h2002, 32'h0, 32'h12F03456, 1, 32'h000000F0, 4'b1111, 32'h0);
    run(0, 1, LD_H, SV_W, 32'h2002, 32'h0, 32'h80017FFF, 5, 32'hFFFF8001, 4'b1111, 32'h0);
    run(0, 1, LD_HU, SV_W, 32'h2002, 32'h0, 32'h80017FFF, 5, 32'h00008001, 4'b1111, 32'h0);
    run(0, 1, LD_W, SV_W, 32'h2000, 32'h0, 32'hDEADBEEF, 2, 32'hDEADBEEF, 4'b1111, 32'h0);
    run(0, 1, LD_H, SV_W, 32'h2000, 32'h0, 32'h12348765, 0, 32'hFFFF8765, 4'b1111, 32'h0);
    run(0, 1, LD_BU, SV_W, 32'h2001, 32'h0, 32'h0000AB00, 0, 32'h000000AB, 4'b1111, 32'h0);
    run(1, 1, LD_W, SV_W, 32'h2008, 32'hCAFEF00D, 32'h0, 0, last_ld, 4'b1111, 32'hCAFEF00D);
    run(1, 0, LD_W, SV_H, 32'h2000, 32'h1234BEEF, 32'h0, 1, last_ld, 4'b0011, 32'hBEEFBEEF);
    // Timeout path on the 4-cycle instance, ack never asserted.
    @(posedge clk); #1;
    acc_valid_to = 1; mem_read = 1; mem_write = 0; load_option = LD_W; addr = 32'h4000;
    sb.push_back('{32'h0, 1'b1});
    rq = 0; fin = 0;
    for (int i = 0; i < 50 && !fin; i++) begin
      @(negedge clk);
      if (done_to) begin
        fin = 1;
        chk("to_req_cycles", rq, 4);
        chk("to_err_with_done", {31'b0, bus_err_to}, 32'd1);
        acc_valid_to = 0;
      end else if (bus_req_to) rq++;
    end
    if (!fin) begin
      fail("to_done_wait");
      acc_valid_to = 0;
    end
    @(negedge clk);
    chk("to_idle", {31'b0, dut_to.state == IDLE}, 32'd1);
    chk("to_err_one_cycle", {31'b0, bus_err_to}, 32'd0);
    // Reset in the middle of a WAIT.
    @(posedge clk); #1;
    acc_valid = 1; mem_read = 1; mem_write = 0; load_option = LD_W; addr = 32'h5000;
    repeat (3) @(negedge clk);
    chk("pre_rst_req", {31'b0, bus_req}, 32'd1);
    rst_n = 0;
    #1;
    chk("rst_req_drop", {31'b0, bus_req}, 32'd0);
    chk("rst_ld_clear", ld_data, 32'd0);
    acc_valid = 0;
    @(negedge clk);
    rst_n = 1;
    last_ld = 32'h0;
    run(1, 0, LD_W, SV_W, 32'h5004, 32'hCAFEF00D, 32'h0, 0, last_ld, 4'b1111, 32'hCAFEF00D);
`ifdef MISALIGN_EXC_EN
    @(posedge clk); #1;
    acc_valid = 1; mem_read = 1; mem_write = 0; load_option = LD_W; addr = 32'h3001;
    sb.push_back('{last_ld, 1'b0});
    @(negedge clk);
    chk("mis_no_req0", {31'b0, bus_req}, 32'd0);
    @(negedge clk);
    chk("mis_no_req1", {31'b0, bus_req}, 32'd0);
    chk("mis_done", {31'b0, done}, 32'd1);
    chk("mis_addr_exc", {31'b0, addr_exc}, 32'd1);
    chk("mis_bad_vaddr", bad_vaddr, 32'h3001);
    acc_valid = 0;
    run(1, 0, LD_W, SV_H, 32'h3002, 32'h0000BEEF, 32'h0, 0, last_ld, 4'b1100, 32'hBEEFBEEF);
`endif
    repeat (3) @(negedge clk);
    if (sb.size() != 0) chk("sb_leftover", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
